// File: rtl/lnx_arbiter.sv
// lnx_arbiter: four-way round-robin front end for one shared Lnx core.
// Each job runs IDLE -> ISSUE -> WAIT -> RESP. A timeout aborts a job
// whose core never answers, and the job then completes with ERR set.
module lnx_arbiter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               RESETstage,
  input  logic [3:0]         REQ,
  input  logic [4*WIDTH-1:0] X_IN,
  output logic [3:0]         GNT,
  output logic [3:0]         DONE,
  output logic [WIDTH-1:0]   Y_OUT,
  output logic               ERR,
  output logic               BUSY,
  output logic               CORE_START,
  output logic [WIDTH-1:0]   CORE_X,
  input  logic               CORE_VALID,
  input  logic [WIDTH-1:0]   CORE_Y
);

  // The timer is at least 8 bits wide and grows if TIMEOUT needs more.
  localparam int TW_RAW = $clog2(TIMEOUT + 1);
  localparam int TW     = (TW_RAW > 8) ? TW_RAW : 8;
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [1:0]          last_q, last_d;
  logic [1:0]          owner_q, owner_d;
  logic [1:0]          winner;
  logic [TW-1:0]       timer_q, timer_d;
  logic [WIDTH-1:0]    core_x_q, core_x_d;
  logic [WIDTH-1:0]    y_q, y_d;
  logic                err_q, err_d;
  logic [3:0][WIDTH-1:0] x_vec;

  assign x_vec = X_IN;

  // Round-robin pick. The search starts at last+1. The loop walks the
  // offsets from far to near, so the nearest requester is written last
  // and wins. Offset 4 wraps back to last, so that requester ranks last.
  always_comb begin
    winner = last_q;
    for (int i = 4; i >= 1; i--) begin
      if (REQ[last_q + 2'(i)]) winner = last_q + 2'(i);
    end
  end

  // Next-state and datapath update for the job FSM.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    timer_d  = timer_q;
    core_x_d = core_x_q;
    y_d      = y_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (|REQ) begin
          owner_d  = winner;
          core_x_d = x_vec[winner];
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        // A core answer in the same cycle as the timeout takes priority.
        if (CORE_VALID) begin
          y_d     = CORE_Y;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timer_q == TMO) begin
          y_d     = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers. Reset sets last to 3, so requester 0 is searched first.
  always_ff @(posedge CLK or negedge RESETstage) begin
    if (!RESETstage) begin
      state_q  <= S_IDLE;
      last_q   <= 2'd3;
      owner_q  <= 2'd0;
      timer_q  <= '0;
      core_x_q <= '0;
      y_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      timer_q  <= timer_d;
      core_x_q <= core_x_d;
      y_q      <= y_d;
      err_q    <= err_d;
    end
  end

  // Grant and done decode for each requester. Both are gated by the state,
  // so they are one-hot and can never be high in the same cycle.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign GNT[g]  = (state_q == S_ISSUE) && (owner_q == 2'(g));
    assign DONE[g] = (state_q == S_RESP)  && (owner_q == 2'(g));
  end

  assign CORE_START = (state_q == S_ISSUE);
  assign BUSY       = (state_q != S_IDLE);
  assign CORE_X     = core_x_q;
  assign Y_OUT      = y_q;
  assign ERR        = err_q;

endmodule

// File: doc/lnx_arbiter.md
LNX_ARBITER -- requirements
Module: lnx_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and result width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum number of WAIT cycles before the arbiter aborts a job.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESETstage, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port REQ, input, 4 bits: one request line per requester (index 0..3).
REQ-006 SHALL have port X_IN, input, 4*WIDTH bits: requester i operand on bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port GNT, output, 4 bits: one-hot, one-cycle grant pulse.
REQ-008 SHALL have port DONE, output, 4 bits: one-hot, one-cycle completion pulse.
REQ-009 SHALL have port Y_OUT, output, WIDTH bits: result, valid while DONE is nonzero.
REQ-010 SHALL have port ERR, output, 1 bit: timeout flag, valid while DONE is nonzero.
REQ-011 SHALL have port BUSY, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port CORE_START, output, 1 bit: one-cycle start pulse to the shared Lnx core.
REQ-013 SHALL have port CORE_X, output, WIDTH bits: registered operand to the core.
REQ-014 SHALL have port CORE_VALID, input, 1 bit: core result-valid pulse.
REQ-015 SHALL have port CORE_Y, input, WIDTH bits: core result.

Function
REQ-016 SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE, REQ==0: SHALL remain in IDLE.
REQ-018 IDLE, REQ!=0: SHALL select the winner round-robin, searching from (LAST+1) mod 4 upward with wrap.
REQ-019 On that same edge SHALL latch OWNER=winner and CORE_X=X_IN slice of the winner, and go to ISSUE.
REQ-020 ISSUE: CORE_START=1 and GNT[OWNER]=1 for exactly this cycle; SHALL clear TIMER and go to WAIT.
REQ-021 WAIT: SHALL increment TIMER (8-bit minimum, saturating) each cycle.
REQ-022 WAIT, CORE_VALID=1: SHALL latch Y_OUT=CORE_Y and ERR=0, and go to RESP.
REQ-023 WAIT, CORE_VALID=0 and TIMER==TIMEOUT: SHALL set Y_OUT=0 and ERR=1, and go to RESP.
REQ-024 WAIT, CORE_VALID=1 and TIMER==TIMEOUT in the same cycle: CORE_VALID SHALL win (ERR=0).
REQ-025 RESP: DONE[OWNER]=1 for exactly one cycle; Y_OUT and ERR stable; SHALL set LAST=OWNER and go to IDLE.
REQ-026 Latency: REQ sampled at edge k -> GNT and CORE_START high during cycle k+1.
REQ-027 Latency: CORE_VALID sampled at edge m -> DONE high during cycle m+1.
REQ-028 Latency: minimum IDLE-to-IDLE turnaround is 4 cycles.
REQ-029 SHALL ignore CORE_VALID in IDLE, ISSUE and RESP.
REQ-030 SHALL ignore REQ outside IDLE; pending requests wait and are never lost while held.
REQ-031 Requesters hold REQ and operand until GNT; a REQ dropped before selection SHALL NOT be granted.
REQ-032 A requester whose REQ is still high after RESP is re-eligible but ranks last; no requester starves while others request.
REQ-033 GNT and DONE SHALL never have more than one bit set, and SHALL never both be nonzero in the same cycle.
REQ-034 Y_OUT and ERR SHALL hold their values until the next RESP.

Reset
REQ-035 RESETstage=0 SHALL immediately (asynchronously) force: state IDLE, LAST=3, OWNER=0, TIMER=0, CORE_X=0, Y_OUT=0, ERR=0.
REQ-036 During reset, GNT, DONE, CORE_START and BUSY SHALL all be 0.
REQ-037 Reset asserted mid-job SHALL abort the job with no DONE pulse; a late CORE_VALID after release SHALL be ignored (FSM is in IDLE).
REQ-038 After release, the first arbitration SHALL give requester 0 top priority.

Verification
REQ-039 Single request: REQ=0001, X0=0x0100, core answers CORE_Y=0x1234 after 5 cycles -> GNT=0001 in cycle 1, DONE=0001 with Y_OUT=0x1234, ERR=0.
REQ-040 Contention: REQ=1111 held -> grant order 0,1,2,3,0; exactly one GNT per job.
REQ-041 Timeout: core never asserts CORE_VALID, TIMEOUT=8 -> DONE after WAIT reaches TIMER=8, Y_OUT=0, ERR=1; the next job is then served normally.
REQ-042 Simultaneous CORE_VALID and TIMER==TIMEOUT -> ERR=0, Y_OUT=CORE_Y.
REQ-043 Reset pulse in WAIT, then CORE_VALID 2 cycles after release -> no DONE, BUSY=0, next REQ=0100 granted normally.
REQ-044 Stray CORE_VALID in IDLE -> no DONE, and Y_OUT unchanged.
